// File: rtl/timer_irq_pkg.sv
// Shared definitions for the 32-bit countdown timer: register map, CTRL field
// layout, controller states and mode encodings.
package timer_irq_pkg;

    localparam int DATA_W = 32;

    // Word addresses as selected by bus byte-address bits [3:2].
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM_BIT  = 3;

    // Mode encodings 2 and 3 are not listed; they fall back to one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    // Field order matches the CTRL bit positions above (im is bit 3).
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_irq.sv
// Memory-mapped 32-bit countdown timer with one-shot and auto-reload modes,
// driving a single maskable interrupt line.
module timer_irq
    import timer_irq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              irq
);

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] preset_q, preset_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    state_e            state_q, state_d;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case/if tree leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // The controller only ever sees the registered En, so a CTRL write
        // influences state transitions from the following cycle onward.
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                state_d = ST_IDLE;
                if (ctrl_q.mode == MODE_AUTO) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (preset_wr) begin
            preset_d = din;
        end

        // A bus write to CTRL is applied last so it wins over both the
        // one-shot En clear and a same-edge interrupt set.
        if (ctrl_wr) begin
            ctrl_d.en   = din[CTRL_EN_BIT];
            ctrl_d.mode = din[CTRL_MODE_HI:CTRL_MODE_LO];
            ctrl_d.im   = din[CTRL_IM_BIT];
            irq_flag_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: dout = preset_q;
            ADDR_COUNT:  dout = count_q;
            default:     dout = '0;
        endcase
    end

    // Built only from flops, so nothing on the bus reaches irq combinationally.
    assign irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_irq.sv
// Directed scenarios with spec-derived constants, followed by random bus
// traffic compared cycle by cycle against a behavioural timer model.
module tb_timer_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_irq dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a timer phase plus the four architectural values.
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_FIRE = 3;

    int unsigned m_ctrl   = 0;
    int unsigned m_preset = 0;
    int unsigned m_count  = 0;
    bit          m_flag   = 1'b0;
    int          m_phase  = PH_IDLE;

    task automatic model_step(input bit rst, input bit w, input logic [1:0] a,
                              input logic [31:0] d);
        bit          en;
        int unsigned mode;
        int          nxt;
        if (rst) begin
            m_ctrl   = 0;
            m_preset = 0;
            m_count  = 0;
            m_flag   = 1'b0;
            m_phase  = PH_IDLE;
        end else begin
            en   = (m_ctrl & 1) != 0;
            mode = (m_ctrl >> 1) & 3;
            nxt  = m_phase;
            if (m_phase == PH_IDLE) begin
                if (en) nxt = PH_LOAD;
            end else if (m_phase == PH_LOAD) begin
                m_count = m_preset;
                nxt     = PH_CNT;
            end else if (m_phase == PH_CNT) begin
                if (!en) nxt = PH_IDLE;
                else if (m_count > 1) m_count = m_count - 1;
                else begin
                    m_count = 0;
                    m_flag  = 1'b1;
                    nxt     = PH_FIRE;
                end
            end else begin
                nxt = PH_IDLE;
                if (mode == 1) m_flag = 1'b0;
                else m_ctrl = m_ctrl & ~32'd1;
            end
            if (w && a == 2'd1) m_preset = d;
            if (w && a == 2'd0) begin
                m_ctrl = d & 32'hF;
                m_flag = 1'b0;
            end
            m_phase = nxt;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_ctrl;
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_flag && ((m_ctrl >> 3) & 1) != 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, let the rising edge act, then
    // settle just after the next falling edge before anything is sampled.
    task automatic cyc(input bit rst, input bit w, input logic [1:0] a, input logic [31:0] d);
        reset = rst;
        we    = w;
        addr  = a;
        din   = d;
        @(posedge clk);
        model_step(rst, w, a, d);
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b0;
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    initial begin
        logic [31:0] v;
        bit          r_rst;
        bit          r_we;
        logic [1:0]  r_a;
        logic [31:0] r_d;

        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;
        @(negedge clk);

        // Reset state.
        cyc(1, 0, 2'd0, 32'd0);
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, 32'd0);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        rd(2'd3, v); check("rst_addr3", v, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // V1: one-shot, PRESET=5, CTRL=0x9 at E.
        cyc(0, 1, 2'd1, 32'd5);
        cyc(0, 1, 2'd0, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 2'd2, 32'd0);
            if (k >= 2) check("v1_count", dout, (k >= 7) ? 32'd0 : 32'(7 - k));
            check("v1_irq", {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
            if (k == 8) begin
                rd(2'd0, v);
                check("v1_ctrl_en_clr", v, 32'h8);
            end
        end
        cyc(0, 1, 2'd0, 32'h0);
        check("v1_irq_cleared", {31'd0, irq}, 32'd0);

        // V2: auto-reload, PRESET=3, CTRL=0xB at E.
        cyc(1, 0, 2'd0, 32'd0);
        cyc(0, 1, 2'd1, 32'd3);
        cyc(0, 1, 2'd0, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            cyc(0, 0, 2'd0, 32'd0);
            check("v2_irq", {31'd0, irq}, (k == 5 || k == 11 || k == 17) ? 32'd1 : 32'd0);
            check("v2_ctrl", dout, 32'hB);
        end

        // V3: masked, PRESET=2, CTRL=0x1.
        cyc(1, 0, 2'd0, 32'd0);
        cyc(0, 1, 2'd1, 32'd2);
        cyc(0, 1, 2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            cyc(0, 0, 2'd2, 32'd0);
            check("v3_irq_masked", {31'd0, irq}, 32'd0);
        end
        check("v3_count_zero", dout, 32'd0);
        cyc(0, 1, 2'd0, 32'h9);
        check("v3_irq_after_unmask", {31'd0, irq}, 32'd0);
        for (int k = 1; k <= 2; k++) begin
            cyc(0, 0, 2'd0, 32'd0);
            check("v3_irq_after_unmask", {31'd0, irq}, 32'd0);
        end

        // V4: disable mid-count, PRESET=10.
        cyc(1, 0, 2'd0, 32'd0);
        cyc(0, 1, 2'd1, 32'd10);
        cyc(0, 1, 2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) cyc(0, 0, 2'd2, 32'd0);
        check("v4_count_before", dout, 32'd6);
        cyc(0, 1, 2'd0, 32'h8);
        for (int k = 1; k <= 15; k++) begin
            cyc(0, 0, 2'd2, 32'd0);
            check("v4_count_hold", dout, 32'd5);
            check("v4_irq", {31'd0, irq}, 32'd0);
        end

        // V5: reset mid-count, PRESET=8.
        cyc(1, 0, 2'd0, 32'd0);
        cyc(0, 1, 2'd1, 32'd8);
        cyc(0, 1, 2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) cyc(0, 0, 2'd2, 32'd0);
        check("v5_count_before", dout, 32'd4);
        cyc(1, 1, 2'd1, 32'd77);
        rd(2'd0, v); check("v5_ctrl", v, 32'd0);
        rd(2'd1, v); check("v5_preset", v, 32'd0);
        rd(2'd2, v); check("v5_count", v, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 2'd2, 32'd0);
            check("v5_no_irq", {31'd0, irq}, 32'd0);
        end

        // V6: PRESET=0, reserved address, read-only COUNT, CTRL upper bits.
        cyc(1, 0, 2'd0, 32'd0);
        cyc(0, 1, 2'd1, 32'd0);
        cyc(0, 1, 2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 2'd0, 32'd0);
            check("v6_irq", {31'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
        end
        rd(2'd3, v); check("v6_addr3", v, 32'd0);
        cyc(0, 1, 2'd2, 32'h1234);
        rd(2'd2, v); check("v6_count_ro", v, 32'd0);
        cyc(0, 1, 2'd1, 32'd7);
        cyc(0, 1, 2'd3, 32'hFFFF_FFFF);
        rd(2'd1, v); check("v6_preset_kept", v, 32'd7);
        rd(2'd3, v); check("v6_addr3_after_wr", v, 32'd0);
        cyc(0, 1, 2'd0, 32'hFFFF_FFF2);
        rd(2'd0, v); check("v6_ctrl_upper", v, 32'h2);

        // Random bus traffic against the model.
        cyc(1, 0, 2'd0, 32'd0);
        for (int n = 0; n < 800; n++) begin
            r_rst = ($urandom_range(0, 149) == 0);
            r_we  = ($urandom_range(0, 5) == 0);
            r_a   = 2'($urandom_range(0, 3));
            if (r_a == 2'd1) r_d = $urandom_range(0, 6);
            else r_d = $urandom;
            cyc(r_rst, r_we, r_a, r_d);
            check("rand_irq", {31'd0, irq}, {31'd0, model_irq()});
            check("rand_dout", dout, model_read(r_a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
